// File: rtl/reg_bus_master_pkg.sv
// reg_bus_master_pkg: FSM states and register map shared by the bus master, its responders and benches.
package reg_bus_master_pkg;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOVER, S_RESP} state_e;

  localparam int A_RAND = 0;
  localparam int A_LED  = 4;

  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction

endpackage

// File: rtl/reg_bus_master.sv
// reg_bus_master: turns a valid/ready command stream into timed register-file strobe cycles.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int WAIT_CYCLES    = 2,
  parameter int RECOVER_CYCLES = 1,
  parameter int ADDR_W         = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              bus_as,
  output logic              bus_rs_n,
  output logic              bus_ws_n,
  output logic [ADDR_W-1:0] bus_address,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic [31:0]       bus_rdata
);

  localparam int CW = cnt_w(WAIT_CYCLES, RECOVER_CYCLES);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_q, wr_d, as_q, as_d, rs_n_q, rs_n_d, ws_n_q, ws_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        be_q, be_d;
  logic              accept;

  assign cmd_ready   = state_q == S_IDLE;
  assign rsp_valid   = state_q == S_RESP;
  assign accept      = cmd_valid && cmd_ready;
  assign rsp_rdata   = rdata_q;
  assign bus_as      = as_q;
  assign bus_rs_n    = rs_n_q;
  assign bus_ws_n    = ws_n_q;
  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_be      = be_q;

  // One down-counter times both the strobe and the recovery phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:    state_d = cmd_valid ? S_SETUP : S_IDLE;
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = CW'(WAIT_CYCLES - 1);
      end
      S_STROBE: begin
        state_d = cnt_q == '0 ? S_RECOVER : S_STROBE;
        cnt_d   = cnt_q == '0 ? CW'(RECOVER_CYCLES - 1) : cnt_q - 1'b1;
      end
      S_RECOVER: begin
        state_d = cnt_q == '0 ? S_RESP : S_RECOVER;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      S_RESP:    state_d = rsp_ready ? S_IDLE : S_RESP;
      default:   state_d = S_IDLE;
    endcase
    wr_d    = accept ? cmd_write : wr_q;
    addr_d  = accept ? cmd_addr : addr_q;
    wdata_d = accept ? cmd_wdata : wdata_q;
    be_d    = accept ? cmd_be : be_q;
    as_d    = state_d == S_SETUP || state_d == S_STROBE;
    rs_n_d  = !(state_d == S_STROBE && !wr_d);
    ws_n_d  = !(state_d == S_STROBE && wr_d);
    rdata_d = (state_q == S_STROBE && cnt_q == '0 && !wr_q) ? bus_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      as_q    <= 1'b0;
      rs_n_q  <= 1'b1;
      ws_n_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      as_q    <= as_d;
      rs_n_q  <= rs_n_d;
      ws_n_q  <= ws_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
